// File: rtl/control_sequencer.sv
// Microcode control sequencer for the 8-bit computer: T-state counter, opcode/flag
// decode into the 16-bit control word, and free-run / single-step gating.
module control_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic        carry_flag,
   input  logic        zero_flag,
   input  logic        run_mode,
   input  logic        step_req,
   output logic [15:0] ctrl,
   output logic [2:0]  t_state,
   output logic        halted,
   output logic        fetch
);

   typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} tstate_e;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
      OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
      OP_OUT = 4'hE, OP_HLT = 4'hF
   } opcode_e;

   localparam logic [15:0] C_HLT = 16'h8000;
   localparam logic [15:0] C_MI  = 16'h4000;
   localparam logic [15:0] C_RI  = 16'h2000;
   localparam logic [15:0] C_RO  = 16'h1000;
   localparam logic [15:0] C_IO  = 16'h0800;
   localparam logic [15:0] C_II  = 16'h0400;
   localparam logic [15:0] C_AI  = 16'h0200;
   localparam logic [15:0] C_AO  = 16'h0100;
   localparam logic [15:0] C_EO  = 16'h0080;
   localparam logic [15:0] C_SU  = 16'h0040;
   localparam logic [15:0] C_BI  = 16'h0020;
   localparam logic [15:0] C_OI  = 16'h0010;
   localparam logic [15:0] C_CE  = 16'h0008;
   localparam logic [15:0] C_CO  = 16'h0004;
   localparam logic [15:0] C_J   = 16'h0002;
   localparam logic [15:0] C_FI  = 16'h0001;

   tstate_e     t_q, t_d;
   logic        halted_q, halted_d;
   logic        step_prev;
   logic        advance;
   logic        last;
   logic [15:0] uword;

   always_ff @(posedge clk) begin
      if (reset) begin
         t_q       <= T0;
         halted_q  <= 1'b0;
         step_prev <= 1'b1;
      end else begin
         t_q       <= t_d;
         halted_q  <= halted_d;
         step_prev <= step_req;
      end
   end

   assign advance = !halted_q && (run_mode || (step_req && !step_prev));

   // Microcode ROM; steps past an opcode's end (opcode changed live) decode as
   // an empty word that closes the instruction.
   always_comb begin
      uword = '0;
      last  = 1'b0;
      case (t_q)
         T0: uword = C_CO | C_MI;
         T1: begin
            uword = C_RO | C_II | C_CE;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
               OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last = 1'b0;
               default: last = 1'b1;
            endcase
         end
         T2: begin
            last = 1'b1;
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  uword = C_IO | C_MI;
                  last  = 1'b0;
               end
               OP_LDI:  uword = C_IO | C_AI;
               OP_JMP:  uword = C_IO | C_J;
               OP_JC:   uword = carry_flag ? (C_IO | C_J) : C_IO;
               OP_JZ:   uword = zero_flag  ? (C_IO | C_J) : C_IO;
               OP_OUT:  uword = C_AO | C_OI;
               OP_HLT:  uword = C_HLT;
               default: uword = '0;
            endcase
         end
         T3: begin
            last = 1'b1;
            case (opcode)
               OP_LDA: uword = C_RO | C_AI;
               OP_ADD, OP_SUB: begin
                  uword = C_RO | C_BI;
                  last  = 1'b0;
               end
               OP_STA:  uword = C_AO | C_RI;
               default: uword = '0;
            endcase
         end
         T4: begin
            last = 1'b1;
            case (opcode)
               OP_ADD:  uword = C_EO | C_AI | C_FI;
               OP_SUB:  uword = C_EO | C_AI | C_SU | C_FI;
               default: uword = '0;
            endcase
         end
         default: begin
            uword = '0;
            last  = 1'b1;
         end
      endcase
   end

   always_comb begin
      t_d      = t_q;
      halted_d = halted_q;
      if (advance) begin
         if (t_q == T2 && opcode == OP_HLT) begin
            halted_d = 1'b1;
            t_d      = T0;
         end else if (last) begin
            t_d = T0;
         end else begin
            t_d = tstate_e'(t_q + 3'd1);
         end
      end
   end

   assign ctrl    = advance ? uword : '0;
   assign t_state = t_q;
   assign halted  = halted_q;
   assign fetch   = (t_q == T0) && !halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, hand-written corner
// sequences, and randomized stimulus against an instruction-level model.
module tb_control_sequencer;

   logic        clk;
   logic        reset;
   logic [3:0]  opcode;
   logic        carry_flag;
   logic        zero_flag;
   logic        run_mode;
   logic        step_req;
   logic [15:0] ctrl;
   logic [2:0]  t_state;
   logic        halted;
   logic        fetch;

   int checks   = 0;
   int failures = 0;

   control_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .run_mode   (run_mode),
      .step_req   (step_req),
      .ctrl       (ctrl),
      .t_state    (t_state),
      .halted     (halted),
      .fetch      (fetch)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        rst;
      logic [3:0]  op;
      logic        c;
      logic        z;
      logic        run;
      logic        step;
      logic [15:0] e_ctrl;
      logic [2:0]  e_t;
      logic        e_h;
      logic        e_f;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 2 ns later, before the rising edge.
   task automatic tick(input logic r, input logic [3:0] op, input logic c, input logic z,
                       input logic run, input logic step);
      @(negedge clk);
      reset = r; opcode = op; carry_flag = c; zero_flag = z; run_mode = run; step_req = step;
      #2;
   endtask

   // Instruction-level reference: each opcode is a list of control words; its length is the step count.
   function automatic int ilen(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic [15:0] word(input logic [3:0] op, input logic c, input logic z, input int idx);
      logic [15:0] w [0:4];
      w = '{16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000};
      case (op)
         4'h1: begin w[2] = 16'h4800; w[3] = 16'h1200; end
         4'h2: begin w[2] = 16'h4800; w[3] = 16'h1020; w[4] = 16'h0281; end
         4'h3: begin w[2] = 16'h4800; w[3] = 16'h1020; w[4] = 16'h02C1; end
         4'h4: begin w[2] = 16'h4800; w[3] = 16'h2100; end
         4'h5: w[2] = 16'h0A00;
         4'h6: w[2] = 16'h0802;
         4'h7: w[2] = c ? 16'h0802 : 16'h0800;
         4'h8: w[2] = z ? 16'h0802 : 16'h0800;
         4'hE: w[2] = 16'h0110;
         4'hF: w[2] = 16'h8000;
         default: ;
      endcase
      return (idx < ilen(op)) ? w[idx] : 16'h0000;
   endfunction

   int   m_idx;
   logic m_halt;
   logic m_prev;

   function automatic logic m_adv();
      return !m_halt && (run_mode || (step_req && !m_prev));
   endfunction

   task automatic model_update();
      logic adv;
      adv = m_adv();
      if (reset) begin
         m_idx = 0; m_halt = 1'b0; m_prev = 1'b1;
      end else begin
         m_prev = step_req;
         if (adv) begin
            if (m_idx == 2 && opcode == 4'hF) begin
               m_halt = 1'b1; m_idx = 0;
            end else if (m_idx >= ilen(opcode) - 1) m_idx = 0;
            else m_idx = m_idx + 1;
         end
      end
   endtask

   int nz;

   initial begin
      reset = 1'b1; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
      run_mode = 1'b0; step_req = 1'b0;

      // rst op c z run step | ctrl t h f
      vecs.push_back('{0, 4'h1, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h1, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 1, 0, 16'h4800, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 1, 0, 16'h1200, 3'd3, 0, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h3, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h3, 0, 0, 1, 0, 16'h4800, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h3, 0, 0, 1, 0, 16'h1020, 3'd3, 0, 0});
      vecs.push_back('{0, 4'h3, 0, 0, 1, 0, 16'h02C1, 3'd4, 0, 0});
      vecs.push_back('{0, 4'h2, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h2, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h2, 0, 0, 1, 0, 16'h4800, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h2, 0, 0, 1, 0, 16'h1020, 3'd3, 0, 0});
      vecs.push_back('{0, 4'h2, 0, 0, 1, 0, 16'h0281, 3'd4, 0, 0});
      vecs.push_back('{0, 4'h7, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h7, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h7, 0, 0, 1, 0, 16'h0800, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h7, 1, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h7, 1, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h7, 1, 0, 1, 0, 16'h0802, 3'd2, 0, 0});
      vecs.push_back('{0, 4'hF, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'hF, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'hF, 0, 0, 1, 0, 16'h8000, 3'd2, 0, 0});
      vecs.push_back('{0, 4'hF, 0, 0, 1, 0, 16'h0000, 3'd0, 1, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 1, 16'h0000, 3'd0, 1, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 0, 16'h0000, 3'd0, 1, 0});
      vecs.push_back('{1, 4'h1, 0, 0, 1, 0, 16'h0000, 3'd0, 1, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 0, 16'h0000, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 1, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 1, 16'h0000, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 0, 16'h0000, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 1, 16'h4800, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 0, 16'h0000, 3'd3, 0, 0});
      vecs.push_back('{1, 4'h1, 0, 0, 0, 0, 16'h0000, 3'd3, 0, 0});
      vecs.push_back('{1, 4'h1, 0, 0, 0, 1, 16'h0000, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 1, 16'h0000, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h1, 0, 0, 0, 0, 16'h0000, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h5, 0, 0, 0, 1, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h5, 0, 0, 1, 1, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h5, 0, 0, 1, 0, 16'h0A00, 3'd2, 0, 0});
      vecs.push_back('{0, 4'hE, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'hE, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'hE, 0, 0, 1, 0, 16'h0110, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h0, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'hB, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h4, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h4, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h4, 0, 0, 1, 0, 16'h4800, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h4, 0, 0, 1, 0, 16'h2100, 3'd3, 0, 0});
      vecs.push_back('{0, 4'h6, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h6, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h6, 0, 0, 1, 0, 16'h0802, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h8, 0, 0, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h8, 0, 0, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h8, 0, 0, 1, 0, 16'h0800, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h8, 0, 1, 1, 0, 16'h4004, 3'd0, 0, 1});
      vecs.push_back('{0, 4'h8, 0, 1, 1, 0, 16'h1408, 3'd1, 0, 0});
      vecs.push_back('{0, 4'h8, 0, 1, 1, 0, 16'h0802, 3'd2, 0, 0});
      vecs.push_back('{0, 4'h8, 0, 1, 1, 0, 16'h4004, 3'd0, 0, 1});

      tick(1, 4'h1, 0, 0, 1, 0);
      tick(1, 4'h1, 0, 0, 1, 0);
      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].rst, vecs[i].op, vecs[i].c, vecs[i].z, vecs[i].run, vecs[i].step);
         check($sformatf("vec%0d.ctrl", i),    ctrl,    vecs[i].e_ctrl);
         check($sformatf("vec%0d.t_state", i), t_state, vecs[i].e_t);
         check($sformatf("vec%0d.halted", i),  halted,  vecs[i].e_h);
         check($sformatf("vec%0d.fetch", i),   fetch,   vecs[i].e_f);
      end

      // Single-step: three key presses of 10 high / 5 low give exactly three advances.
      tick(1, 4'h1, 0, 0, 0, 0);
      tick(0, 4'h1, 0, 0, 0, 0);
      nz = 0;
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 15; k++) begin
            tick(0, 4'h1, 0, 0, 0, (k < 10) ? 1'b1 : 1'b0);
            if (ctrl != 16'h0000) nz++;
         end
      end
      check("step_nonzero_cycles", nz, 3);
      check("step_final_t_state", t_state, 3);

      // Halt holds under step toggles and run_mode changes until reset.
      tick(1, 4'hF, 0, 0, 1, 0);
      tick(0, 4'hF, 0, 0, 1, 0);
      tick(0, 4'hF, 0, 0, 1, 0);
      tick(0, 4'hF, 0, 0, 1, 0);
      check("hlt_t2_ctrl", ctrl, 16'h8000);
      for (int k = 0; k < 20; k++) begin
         tick(0, 4'h1, 0, 0, k[1], k[0]);
         check("halted_hold", {halted, fetch, ctrl}, {1'b1, 1'b0, 16'h0000});
      end
      tick(1, 4'h1, 0, 0, 1, 0);
      tick(0, 4'h1, 0, 0, 1, 0);
      check("hlt_reset_release", {halted, ctrl}, {1'b0, 16'h4004});

      // Reset in T3 of ADD abandons the instruction.
      tick(0, 4'h2, 0, 0, 1, 0);
      tick(0, 4'h2, 0, 0, 1, 0);
      tick(1, 4'h2, 0, 0, 1, 0);
      check("add_t3_before_reset", {t_state, ctrl}, {3'd3, 16'h1020});
      tick(0, 4'h2, 0, 0, 1, 0);
      check("add_reset_recover", {t_state, halted, ctrl}, {3'd0, 1'b0, 16'h4004});

      // Randomized stimulus against the instruction-level model.
      tick(1, 4'h0, 0, 0, 0, 0);
      m_idx = 0; m_halt = 1'b0; m_prev = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         tick(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)), 1'($urandom),
              1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
         check("rand.ctrl", ctrl, m_adv() ? word(opcode, carry_flag, zero_flag, m_idx) : 16'h0000);
         check("rand.t_state", t_state, m_idx);
         check("rand.halted", halted, m_halt);
         check("rand.fetch", fetch, (m_idx == 0) && !m_halt);
         model_update();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcode control sequencer for the 8-bit computer. It steps a T-state counter through the fetch/execute cycle of each instruction, decodes the IR opcode nibble and ALU flags into the 16-bit control word that drives the bus, register, RAM, ALU, PC and output loads, and gates that word for free-run or single-step operation. It sits between the instruction register/flags register and every load/enable pin of the datapath.

## Interface
Parameters:
- none (instruction set, control-word map and step counts are fixed)

Ports:
- clk  in  1  system clock; every datapath register samples on the same rising edge
- reset  in  1  synchronous, active-high; only reset source
- opcode  in  4  IR[7:4]
- carry_flag  in  1  registered ALU carry from the flags register
- zero_flag  in  1  registered ALU zero from the flags register
- run_mode  in  1  1 = free-run, 0 = single-step
- step_req  in  1  debounced, active-high step key level
- ctrl  out  16  control word: [15] hlt, [14] mi, [13] ri, [12] ro, [11] io, [10] ii, [9] ai, [8] ao, [7] eo, [6] su, [5] bi, [4] oi, [3] ce, [2] co, [1] j, [0] fi
- t_state  out  3  current T-state, 0..4
- halted  out  1  HLT executed
- fetch  out  1  high while t_state == 0 and not halted (instruction boundary)

## Operation
- advance = !halted & (run_mode | (step_req & !step_prev)); step_prev is a register tracking step_req.
- ctrl = microcode(t_state, opcode, flags) when advance, else 16'h0000. Combinational from registered state and inputs.
- Common fetch: T0 co|mi (0x4004); T1 ro|ii|ce (0x1408).
- Execute (T2, T3, T4):
  - 1 LDA: io|mi; ro|ai.
  - 2 ADD: io|mi; ro|bi; eo|ai|fi (0x0281).
  - 3 SUB: as ADD, with su in T4 (0x02C1).
  - 4 STA: io|mi; ao|ri.
  - 5 LDI: io|ai.
  - 6 JMP: io|j (0x0802).
  - 7 JC: io|j if carry_flag, else io only (0x0800).
  - 8 JZ: as JC using zero_flag.
  - E OUT: ao|oi.
  - F HLT: hlt (0x8000).
  - 0 and 9..D: NOP, no execute steps.
- Variable length. The last step of each opcode returns to T0 on advance.
  - NOP ends at T1.
  - LDI, JMP, JC, JZ, OUT end at T2. Conditional jumps take 3 steps whether or not they are taken.
  - LDA, STA end at T3.
  - ADD, SUB end at T4.
- HLT: an advance in T2 with opcode F sets halted and t_state = 0. While halted, ctrl = 0, fetch = 0, and step_req/run_mode are ignored. Only reset clears halted.
- opcode and flags are sampled live every cycle. The IR loads at the end of T1, so opcode is valid from T2.

## Timing
- Reset (wins over all other events): t_state = 0, halted = 0, step_prev = 1. A key held through reset therefore produces no step. The next cycle shows ctrl = 0x4004 if run_mode = 1.
- Free-run: one T-state per clk. Instruction lengths are 2–5 cycles.
- Single-step: exactly one T-state advance per rising edge of step_req. ctrl is nonzero for that single cycle only. Holding step_req high does not repeat.
- step_req while run_mode = 1: ignored, no extra advance. step_prev still tracks it.
- run_mode changed mid-instruction: the sequence continues from the current t_state. No restart.
- Reset mid-instruction: the instruction is abandoned, and t_state = 0 on the next cycle.
- t_state never exceeds 4. Any illegal value (5–7) returns to 0 on the next advance with ctrl = 0.

## Test plan
- Reset, run_mode = 1, opcode = 1 held → t_state 0,1,2,3,0,…; ctrl 0x4004, 0x1408, 0x4800, 0x1200, repeating; fetch high on every T0.
- opcode = 3, run_mode = 1 → five-cycle loop; T4 ctrl = 0x02C1. With opcode = 2, T4 ctrl = 0x0281.
- opcode = 7: carry_flag = 0 → T2 ctrl = 0x0800; carry_flag = 1 → T2 ctrl = 0x0802. Both return to T0 the cycle after T2.
- run_mode = 0, step_req high for 10 cycles then low for 5, repeated 3 times → exactly 3 advances, each with one nonzero ctrl cycle; t_state = 3 with opcode 1.
- opcode = F, run_mode = 1 → T2 ctrl = 0x8000, then halted = 1 and ctrl = 0 for 20 cycles under step toggles; reset → halted = 0, ctrl = 0x4004.
- Reset asserted at T3 of ADD → following cycle t_state = 0, ctrl = 0x4004, halted = 0.
